// File: rtl/fifo_pkg.sv
// Shared constants for the processor FIFO: default geometry and the
// boolean constants used by both this buffer and the control FSM.
package fifo_pkg;

    localparam int   FIFO_DATA_WIDTH = 16;
    localparam int   FIFO_DEPTH      = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/fifo_buffer_if.sv
// Strobe/status bundle between the FIFO control logic (master) and the
// storage end of the FIFO (slave).
interface fifo_buffer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);

    // Strobe semantics: wr_en/rd_en are single-cycle requests sampled on
    // the rising edge. A write takes effect only when full is low, and a
    // read only when empty is low. Requests that violate the status are
    // dropped silently. There is no ready/ack; full/empty act as the
    // back-pressure.
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one write port and one registered
// read port. The array itself is never reset; only the read register is.
module fifo_mem #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 8,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register holds its value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_buffer.sv
// Storage and status end of the processor FIFO: pointers, occupancy counter,
// full/empty decode and optional sticky error flags (FIFO_ERR_FLAGS_EN).
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fifo_buffer_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] count;
    logic            full;
    logic            empty;
    logic            wr_acc;
    logic            rd_acc;

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    // Gating with rst keeps a reset cycle from touching the array.
    assign wr_acc = rst && bus.wr_en && !full;
    assign rd_acc = rst && bus.rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.data_in),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (bus.data_out)
    );

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= FALSE;
            underflow <= FALSE;
        end else begin
            if (bus.wr_en && full)  overflow  <= TRUE;
            if (bus.rd_en && empty) underflow <= TRUE;
        end
    end

    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
`else
    assign bus.overflow  = FALSE;
    assign bus.underflow = FALSE;
`endif

    // The extra pointer bit makes the pointer distance equal the occupancy.
    ptr_count_consistent: assert property (
        @(posedge clk) disable iff (!rst) (wr_ptr - rd_ptr) == count
    );

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: table-driven fill/drain plus
// hand-written boundary sequences and random traffic against a queue model.
module tb_fifo_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fifo_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [3:0]    exp_count;
        logic          exp_full;
        logic          exp_empty;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t          vecs [16];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_udf;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " count"},     32'(bus.count),    32'(exp_q.size()));
        chk({tag, " full"},      32'(bus.full),     32'(exp_q.size() == DEPTH));
        chk({tag, " empty"},     32'(bus.empty),    32'(exp_q.size() == 0));
        chk({tag, " data_out"},  32'(bus.data_out), 32'(exp_dout));
        chk({tag, " overflow"},  32'(bus.overflow), 32'(exp_ovf));
        chk({tag, " underflow"}, 32'(bus.underflow), 32'(exp_udf));
    endtask

    // One clock of traffic: the model consumes the strobes, then the DUT is
    // compared #1 after the edge.
    task automatic do_cycle(input logic wr, input logic rd, input logic [DW-1:0] din,
                            input string tag);
        bit w_ok;
        bit r_ok;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = din;
        w_ok = wr && (exp_q.size() < DEPTH);
        r_ok = rd && (exp_q.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
        if (wr && exp_q.size() == DEPTH) exp_ovf = 1'b1;
        if (rd && exp_q.size() == 0)     exp_udf = 1'b1;
`endif
        if (r_ok) exp_dout = exp_q.pop_front();
        if (w_ok) exp_q.push_back(din);
        @(posedge clk);
        #1;
        check_all(tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    // Reset with a write strobe asserted: the strobe must be ignored.
    task automatic do_reset(input string tag);
        rst         = 1'b0;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b0;
        bus.data_in = 16'hDEAD;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        chk({tag, " count"},    32'(bus.count),    32'd0);
        chk({tag, " empty"},    32'(bus.empty),    32'd1);
        chk({tag, " full"},     32'(bus.full),     32'd0);
        chk({tag, " data_out"}, 32'(bus.data_out), 32'd0);
        chk({tag, " overflow"}, 32'(bus.overflow), 32'd0);
        bus.wr_en = 1'b0;
        rst       = 1'b1;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        exp_dout    = '0;
        exp_ovf     = 1'b0;
        exp_udf     = 1'b0;

        for (int i = 0; i < 8; i++) begin
            vecs[i]     = '{1'b1, 1'b0, DW'(i + 1), 4'(i + 1), (i == 7), 1'b0, 16'h0000};
            vecs[i + 8] = '{1'b0, 1'b1, 16'h0000, 4'(7 - i), 1'b0, (i == 7), DW'(i + 1)};
        end

        do_reset("reset0");

        // Fill 0x0001..0x0008 then drain in order.
        for (int i = 0; i < 16; i++) begin
            do_cycle(vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_count", i), 32'(bus.count),    32'(vecs[i].exp_count));
            chk($sformatf("vec%0d tbl_full", i),  32'(bus.full),     32'(vecs[i].exp_full));
            chk($sformatf("vec%0d tbl_empty", i), 32'(bus.empty),    32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d tbl_dout", i),  32'(bus.data_out), 32'(vecs[i].exp_dout));
        end

        // Wrap-around: pointers start at 8 here, so the second burst wraps.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, DW'($urandom_range(0, 16'hFFFF)), "wrap_w5");
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, '0, "wrap_r5");
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, DW'(16'hA0 + i), "wrap_w6");
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b0, 1'b1, '0, "wrap_r6");
            chk("wrap_r6 literal", 32'(bus.data_out), 32'(16'hA0 + i));
        end
        chk("wrap end count", 32'(bus.count), 32'd0);

        // Both strobes while empty: write only, data_out holds 0xA5.
        do_cycle(1'b1, 1'b1, 16'h0055, "both_empty");
        chk("both_empty count_lit", 32'(bus.count),    32'd1);
        chk("both_empty dout_lit",  32'(bus.data_out), 32'h00A5);

        // Fill to full, then both strobes: read only, oldest (0x55) out.
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, DW'(16'h0100 + i), "fill");
        do_cycle(1'b1, 1'b1, 16'h0BAD, "both_full");
        chk("both_full count_lit", 32'(bus.count),    32'd7);
        chk("both_full dout_lit",  32'(bus.data_out), 32'h0055);

        // Refill, then write while full: contents must stay intact.
        do_cycle(1'b1, 1'b0, 16'h0200, "refill");
        do_cycle(1'b1, 1'b0, 16'hBEEF, "write_full");
        do_cycle(1'b1, 1'b1, 16'hCAFE, "both_full2");
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, '0, "drain_under");
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b1, DW'(16'h0300 + i), "traffic");

        // Random traffic, then a reset must clear flags and data_out.
        for (int i = 0; i < 300; i++)
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     DW'($urandom_range(0, 16'hFFFF)), "random");
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, DW'(16'h0400 + i), "prefill");
        do_cycle(1'b1, 1'b0, 16'h0999, "ovf_again");
        do_cycle(1'b0, 1'b1, '0, "read_before_reset");
        do_reset("reset1");
        do_cycle(1'b0, 1'b0, '0, "idle_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Storage and status end of the processor FIFO: a synchronous circular buffer that performs the write and read strobes produced by the FIFO control logic (`wr_en`/`rd_en`) and returns the `full`/`empty` status that logic uses to gate further requests. It holds the data array, read/write pointers and an occupancy counter, and presents registered read data to the processor side.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each stored word
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `ADDR_W`, `$clog2(DEPTH)`, derived; do not override

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset; sampled on rising `clk`
- `wr_en`  in  1  write strobe from FIFO control
- `rd_en`  in  1  read strobe from FIFO control
- `data_in`  in  DATA_WIDTH  word written when a write is accepted
- `data_out`  out  DATA_WIDTH  registered read data
- `full`  out  1  occupancy == DEPTH
- `empty`  out  1  occupancy == 0
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: write attempted while full (see Configuration)
- `underflow`  out  1  sticky: read attempted while empty (see Configuration)

## Operation
- Write accepted iff `wr_en && !full`: `mem[wr_ptr] <= data_in`, `wr_ptr` increments.
- Read accepted iff `rd_en && !empty`: `data_out <= mem[rd_ptr]`, `rd_ptr` increments.
- The block guards itself; strobes violating status are ignored even though upstream already gates them.
- Pointers are ADDR_W+1 bits; the low ADDR_W bits address memory and wrap DEPTH-1 → 0 naturally; the MSB is unused by status (status comes from `count`).
- `count`: +1 on write-only accept, −1 on read-only accept, unchanged on both or neither.
- Simultaneous `wr_en`/`rd_en`:
  - neither full nor empty: both accepted, `count` unchanged.
  - empty: write accepted, read ignored; `count` 0→1, `data_out` holds.
  - full: read accepted, write ignored; `count` DEPTH→DEPTH-1.
- `data_out` holds its last value when no read is accepted.
- Memory contents are not reset.

## Timing
- On a rising edge with `rst`=0: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `data_out`=0, `overflow`=0, `underflow`=0; thus `empty`=1, `full`=0. A reset overrides any strobe in the same cycle; in-flight data is discarded.
- `full`, `empty` are combinational decodes of the `count` register, so they change in the cycle after the accepting edge.
- Read latency: `rd_en` sampled at edge N → `data_out` valid after edge N, stable through edge N+1.
- Write-to-read: a word written at edge N is readable by `rd_en` sampled at edge N+1 (`empty` deasserts after edge N).
- Throughput: one write and one read per cycle.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined: `overflow` sets on `wr_en && full` and `underflow` sets on `rd_en && empty`; both stay set until reset.
- Not defined: `overflow` and `underflow` are constant 0; no error registers are synthesized. The ports are present in both builds.

## Structure
- `fifo_pkg` holds `DATA_WIDTH`/`DEPTH` defaults and the `TRUE`/`FALSE` constants shared with the control FSM.
- Sub-module `fifo_mem`: simple dual-port register array with one write port and one registered read port. `fifo_buffer` owns the pointers, counter, flags and error logic.

## Test plan
- Reset check: hold `rst`=0 with `wr_en`=1 → after the edge, `count`=0, `empty`=1, `full`=0, `data_out`=0.
- Fill and drain: write 0x0001..0x0008 → `full`=1 and `count`=8 after the 8th edge. Read 8 times → 0x0001..0x0008 in order, then `empty`=1.
- Wrap-around: write 5, read 5, then write 6 (0xA0..0xA5), then read 6 → data in order with pointers wrapped, `count` ends at 0.
- Simultaneous access at the boundaries:
  - empty with `wr_en`+`rd_en` and `data_in`=0x55 → `count`=1, `data_out` unchanged.
  - full with both strobes → `count`=7, oldest word on `data_out`.
- Error flags: with `FIFO_ERR_FLAGS_EN`, write while full → `overflow`=1, contents unchanged, stays 1 after further traffic until reset. Without the macro → `overflow` and `underflow` stay 0.
